// File: rtl/keycode_event_decoder.sv
// Keycode PIO receiver: waits for the three HID slots to settle, diffs the settled snapshot
// against the last committed one and queues press/release events; also exports held-key flags.
module keycode_event_decoder #(
  parameter int         STABLE_CYCLES = 1000,
  parameter int         FIFO_DEPTH    = 8,
  parameter logic [7:0] HELD_CODE0    = 8'h1A,
  parameter logic [7:0] HELD_CODE1    = 8'h04,
  parameter logic [7:0] HELD_CODE2    = 8'h16,
  parameter logic [7:0] HELD_CODE3    = 8'h07
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  input  logic [7:0] keycode2,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_press,
  output logic [3:0] held,
  output logic       rollover_err,
  output logic       overflow,
  input  logic       ovf_clr
);

  localparam int CW = $clog2(STABLE_CYCLES + 2);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;
  localparam logic [CW-1:0] CNT_TRIG = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_SAT  = CW'(STABLE_CYCLES + 1);
  localparam logic [NW-1:0] CNT_FULL = NW'(FIFO_DEPTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CHECK  = 2'd1;
  localparam logic [1:0] DIFF   = 2'd2;
  localparam logic [1:0] COMMIT = 2'd3;

  logic [2:0][7:0] cur, in_q, snap, prev;
  logic [CW-1:0]   cnt;
  logic [1:0]      state;
  logic [2:0]      step;
  logic            trig;

  logic [8:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [NW-1:0]   count;

  logic            diff_hit, diff_press;
  logic [7:0]      diff_code;
  logic [1:0]      slot;
  logic [2:0][7:0] other, earlier;
  logic            found, dup;
  logic            push, pop, full, do_push, drop;

  // HID phantom/error codes mark a rollover report that must not be committed
  function automatic logic has_err(input logic [2:0][7:0] s);
    logic e;
    e = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (s[i] >= 8'h01 && s[i] <= 8'h03) e = 1'b1;
    end
    return e;
  endfunction

  function automatic logic has_code(input logic [2:0][7:0] s, input logic [7:0] c);
    return (s[0] == c) || (s[1] == c) || (s[2] == c);
  endfunction

  function automatic logic [7:0] pick(input logic [2:0][7:0] s, input logic [1:0] k);
    case (k)
      2'd0:    return s[0];
      2'd1:    return s[1];
      2'd2:    return s[2];
      default: return 8'h00;
    endcase
  endfunction

  assign cur  = {keycode2, keycode1, keycode0};
  assign trig = (cnt == CNT_TRIG) && (state == IDLE);

  // Stability filter: counter restarts on any slot change and saturates past the trigger value
  always_ff @(posedge Clk) begin
    if (Reset) begin
      in_q <= '0;
      cnt  <= '0;
    end else begin
      in_q <= cur;
      if (cur != in_q)      cnt <= '0;
      else if (cnt != CNT_SAT) cnt <= cnt + CW'(1);
      else                  cnt <= cnt;
    end
  end

  // Releases walk prev slots (steps 0-2), presses walk snap slots (steps 3-5); duplicates collapse
  always_comb begin
    diff_hit   = 1'b0;
    diff_press = 1'b0;
    diff_code  = 8'h00;
    slot       = 2'd0;
    other      = '0;
    earlier    = '0;
    found      = 1'b0;
    dup        = 1'b0;
    if (state == DIFF) begin
      if (step < 3'd3) begin
        slot    = step[1:0];
        other   = snap;
        earlier = prev;
      end else begin
        slot       = 2'(step - 3'd3);
        other      = prev;
        earlier    = snap;
        diff_press = 1'b1;
      end
      diff_code = pick(earlier, slot);
      for (int j = 0; j < 3; j++) begin
        if (other[j] == diff_code) found = 1'b1;
        if (j < int'(slot) && earlier[j] == diff_code) dup = 1'b1;
      end
      diff_hit = (diff_code != 8'h00) && !found && !dup;
    end else begin
      diff_hit = 1'b0;
    end
  end

  // Snapshot sequencer
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      step         <= 3'd0;
      snap         <= '0;
      prev         <= '0;
      held         <= 4'b0000;
      rollover_err <= 1'b0;
    end else begin
      rollover_err <= 1'b0;
      case (state)
        IDLE: begin
          if (trig) begin
            snap  <= in_q;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (has_err(snap)) begin
            rollover_err <= 1'b1;
            state        <= IDLE;
          end else begin
            step  <= 3'd0;
            state <= DIFF;
          end
        end
        DIFF: begin
          if (step == 3'd5) state <= COMMIT;
          else              step  <= step + 3'd1;
        end
        COMMIT: begin
          prev  <= snap;
          held  <= {has_code(snap, HELD_CODE3), has_code(snap, HELD_CODE2),
                    has_code(snap, HELD_CODE1), has_code(snap, HELD_CODE0)};
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign push    = diff_hit;
  assign pop     = ev_valid && ev_ready;
  assign full    = (count == CNT_FULL);
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;

  // Event FIFO; the head entry drives the event outputs directly from storage
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 9'h000;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= {diff_press, diff_code};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + NW'(do_push) - NW'(pop);
      if (ovf_clr)   overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
      else           overflow <= overflow;
    end
  end

  assign ev_valid = (count != '0);
  assign ev_press = mem[rd_ptr][8];
  assign ev_code  = mem[rd_ptr][7:0];

endmodule
